life_cursor_rpt: RTL and testbench

Grid cursor controller for the life board, with auto-repeat and edge handling. It decodes the 3-bit front-panel key code and moves a cursor across an X-by-Y grid. A key press moves the cursor immediately, and holding the key auto-repeats after a programmable delay and rate. Grid dimensions need not be powers of two, and the edge behaviour is selectable: wrap or clamp. It sits between the key decoder and the display/edit logic, which consume `cursor_x`/`cursor_y` and the `moved` strobe.

---
 rtl/life_cursor_rpt_if.sv | 37 +++
 rtl/life_cursor_rpt.sv | 168 ++++++++++++++++
 tb/tb_life_cursor_rpt.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_cursor_rpt_if.sv
// rtl/life_cursor_rpt_if.sv - key input and cursor output bundle for life_cursor_rpt

`ifndef KEY_UP
`define KEY_UP    3'd1
`endif
`ifndef KEY_DOWN
`define KEY_DOWN  3'd2
`endif
`ifndef KEY_LEFT
`define KEY_LEFT  3'd3
`endif
`ifndef KEY_RIGHT
`define KEY_RIGHT 3'd4
`endif

interface life_cursor_rpt_if #(
   parameter int LOG2X = 3,
   parameter int LOG2Y = 3
);
   logic [2:0]       keys;
   logic [LOG2X-1:0] cursor_x;
   logic [LOG2Y-1:0] cursor_y;
   logic             moved;
   logic             blocked;

   // key decoder side drives keys and observes the cursor
   modport master (
      output keys,
      input  cursor_x, cursor_y, moved, blocked
   );

   // cursor controller side
   modport slave (
      input  keys,
      output cursor_x, cursor_y, moved, blocked
   );
endinterface

// File: rtl/life_cursor_rpt.sv
// rtl/life_cursor_rpt.sv - grid cursor controller with key auto-repeat and wrap/clamp edges

`ifndef KEY_UP
`define KEY_UP    3'd1
`endif
`ifndef KEY_DOWN
`define KEY_DOWN  3'd2
`endif
`ifndef KEY_LEFT
`define KEY_LEFT  3'd3
`endif
`ifndef KEY_RIGHT
`define KEY_RIGHT 3'd4
`endif

module life_cursor_rpt #(
   parameter int X         = 8,
   parameter int Y         = 8,
   parameter int LOG2X     = 3,
   parameter int LOG2Y     = 3,
   parameter int HOME_X    = 0,
   parameter int HOME_Y    = 0,
   parameter int WRAP      = 1,
   parameter int RPT_DELAY = 16,
   parameter int RPT_RATE  = 4,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   life_cursor_rpt_if.slave   bus
);

   // idle code must not collide with any direction code
   localparam logic [2:0]       K_IDLE  = 3'd0;
   localparam logic [LOG2X-1:0] X_MAX   = LOG2X'(X - 1);
   localparam logic [LOG2Y-1:0] Y_MAX   = LOG2Y'(Y - 1);
   localparam logic [LOG2X-1:0] X_HOME  = LOG2X'(HOME_X);
   localparam logic [LOG2Y-1:0] Y_HOME  = LOG2Y'(HOME_Y);
   localparam logic [CNT_W-1:0] C_DELAY = CNT_W'(RPT_DELAY);
   localparam logic [CNT_W-1:0] C_RATE  = CNT_W'(RPT_RATE);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   logic [2:0]       r_k_q;
   logic [2:0]       r_k_p;
   logic [CNT_W-1:0] r_cnt;
   logic [LOG2X-1:0] r_x;
   logic [LOG2Y-1:0] r_y;
   logic             r_moved;
   logic             r_blocked;

   logic             w_is_dir;
   logic             w_press;
   logic             w_rpt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [LOG2X-1:0] w_x_nxt;
   logic [LOG2Y-1:0] w_y_nxt;
   logic             w_moved_nxt;
   logic             w_blocked_nxt;

   assign w_is_dir = (r_k_q == `KEY_UP)   || (r_k_q == `KEY_DOWN) ||
                     (r_k_q == `KEY_LEFT) || (r_k_q == `KEY_RIGHT);
   // a new direction (including a change without release) is a press
   assign w_press  = w_is_dir && (r_k_q != r_k_p);
   // counter only reaches 1 while the same direction is held
   assign w_rpt    = w_is_dir && !w_press && (r_cnt == C_ONE);

   // two-stage key pipeline: current sample and previous sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_k_q <= K_IDLE;
         r_k_p <= K_IDLE;
      end else begin
         r_k_q <= bus.keys;
         r_k_p <= r_k_q;
      end
   end

   // next repeat count, next position and edge outcome for this cycle's event
   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_moved_nxt   = 1'b0;
      w_blocked_nxt = 1'b0;

      if (!w_is_dir)
         w_cnt_nxt = '0;
      else if (w_press)
         w_cnt_nxt = C_DELAY;
      else if (w_rpt)
         w_cnt_nxt = C_RATE;
      else if (r_cnt != '0)
         w_cnt_nxt = r_cnt - C_ONE;

      if (w_press || w_rpt) begin
         case (r_k_q)
            `KEY_LEFT: begin
               if (r_x != X_MAX) begin
                  w_x_nxt     = r_x + 1'b1;
                  w_moved_nxt = 1'b1;
               end else if (WRAP != 0) begin
                  w_x_nxt     = '0;
                  w_moved_nxt = 1'b1;
               end else begin
                  w_blocked_nxt = 1'b1;
               end
            end
            `KEY_RIGHT: begin
               if (r_x != '0) begin
                  w_x_nxt     = r_x - 1'b1;
                  w_moved_nxt = 1'b1;
               end else if (WRAP != 0) begin
                  w_x_nxt     = X_MAX;
                  w_moved_nxt = 1'b1;
               end else begin
                  w_blocked_nxt = 1'b1;
               end
            end
            `KEY_DOWN: begin
               if (r_y != Y_MAX) begin
                  w_y_nxt     = r_y + 1'b1;
                  w_moved_nxt = 1'b1;
               end else if (WRAP != 0) begin
                  w_y_nxt     = '0;
                  w_moved_nxt = 1'b1;
               end else begin
                  w_blocked_nxt = 1'b1;
               end
            end
            `KEY_UP: begin
               if (r_y != '0) begin
                  w_y_nxt     = r_y - 1'b1;
                  w_moved_nxt = 1'b1;
               end else if (WRAP != 0) begin
                  w_y_nxt     = Y_MAX;
                  w_moved_nxt = 1'b1;
               end else begin
                  w_blocked_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // registered cursor, strobes and repeat counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_x       <= X_HOME;
         r_y       <= Y_HOME;
         r_moved   <= 1'b0;
         r_blocked <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_x       <= w_x_nxt;
         r_y       <= w_y_nxt;
         r_moved   <= w_moved_nxt;
         r_blocked <= w_blocked_nxt;
      end
   end

   assign bus.cursor_x = r_x;
   assign bus.cursor_y = r_y;
   assign bus.moved    = r_moved;
   assign bus.blocked  = r_blocked;

endmodule

// File: tb/tb_life_cursor_rpt.sv
// tb/tb_life_cursor_rpt.sv - self-checking bench for life_cursor_rpt against a hold-age model

`ifndef KEY_UP
`define KEY_UP    3'd1
`endif
`ifndef KEY_DOWN
`define KEY_DOWN  3'd2
`endif
`ifndef KEY_LEFT
`define KEY_LEFT  3'd3
`endif
`ifndef KEY_RIGHT
`define KEY_RIGHT 3'd4
`endif

module tb_life_cursor_rpt;

   localparam logic [2:0] K_NONE = 3'd0;
   localparam logic [2:0] K_UP   = `KEY_UP;
   localparam logic [2:0] K_DN   = `KEY_DOWN;
   localparam logic [2:0] K_LF   = `KEY_LEFT;
   localparam logic [2:0] K_RT   = `KEY_RIGHT;

   // three configurations: wrap 5x3 home (2,1); clamp 5x3 no repeat; wrap 8x8 fast repeat
   int px[3] = '{5, 5, 8};
   int py[3] = '{3, 3, 8};
   int phx[3] = '{2, 0, 0};
   int phy[3] = '{1, 0, 0};
   int pw[3] = '{1, 0, 1};
   int pd[3] = '{16, 0, 8};
   int pr[3] = '{4, 1, 3};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   life_cursor_rpt_if #(.LOG2X(3), .LOG2Y(2)) if0 ();
   life_cursor_rpt_if #(.LOG2X(3), .LOG2Y(2)) if1 ();
   life_cursor_rpt_if #(.LOG2X(3), .LOG2Y(3)) if2 ();

   life_cursor_rpt #(.X(5), .Y(3), .LOG2X(3), .LOG2Y(2), .HOME_X(2), .HOME_Y(1),
                     .WRAP(1), .RPT_DELAY(16), .RPT_RATE(4), .CNT_W(8))
      u0 (.clk(clk), .reset(reset), .bus(if0));
   life_cursor_rpt #(.X(5), .Y(3), .LOG2X(3), .LOG2Y(2), .HOME_X(0), .HOME_Y(0),
                     .WRAP(0), .RPT_DELAY(0), .RPT_RATE(1), .CNT_W(8))
      u1 (.clk(clk), .reset(reset), .bus(if1));
   life_cursor_rpt #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .HOME_X(0), .HOME_Y(0),
                     .WRAP(1), .RPT_DELAY(8), .RPT_RATE(3), .CNT_W(8))
      u2 (.clk(clk), .reset(reset), .bus(if2));

   // model state: expected outputs, keys driven, last two sampled keys, hold age
   int         mx[3], my[3];
   logic       mmov[3], mblk[3];
   logic [2:0] kin[3], ks1[3], ks2[3];
   int         age[3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nmov2 = 0;

   function automatic bit is_dir(logic [2:0] k);
      return (k == K_UP) || (k == K_DN) || (k == K_LF) || (k == K_RT);
   endfunction

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mx[i] = phx[i]; my[i] = phy[i];
         mmov[i] = 1'b0; mblk[i] = 1'b0;
         ks1[i] = K_NONE; ks2[i] = K_NONE;
         age[i] = 0;
      end
   endtask

   // one clock edge: decide from the key sampled at the previous edge and how long it has been held
   task automatic model_edge(int i);
      logic [2:0] kq;
      logic [2:0] kp;
      bit go;
      int dx, dy, nx, ny;
      kq = ks1[i]; kp = ks2[i];
      go = 1'b0; dx = 0; dy = 0;
      mmov[i] = 1'b0; mblk[i] = 1'b0;
      if (is_dir(kq)) begin
         if (kq != kp) age[i] = 0;
         else          age[i] = age[i] + 1;
         go = (age[i] == 0) ||
              (pd[i] > 0 && age[i] >= pd[i] && ((age[i] - pd[i]) % pr[i]) == 0);
      end else begin
         age[i] = 0;
      end
      if (go) begin
         if (kq == K_LF) dx = 1;
         if (kq == K_RT) dx = -1;
         if (kq == K_DN) dy = 1;
         if (kq == K_UP) dy = -1;
         nx = mx[i] + dx;
         ny = my[i] + dy;
         if (nx >= 0 && nx < px[i] && ny >= 0 && ny < py[i]) begin
            mx[i] = nx; my[i] = ny; mmov[i] = 1'b1;
         end else if (pw[i] != 0) begin
            mx[i] = (nx + px[i]) % px[i];
            my[i] = (ny + py[i]) % py[i];
            mmov[i] = 1'b1;
         end else begin
            mblk[i] = 1'b1;
         end
      end
      ks2[i] = ks1[i];
      ks1[i] = kin[i];
   endtask

   task automatic check_all();
      chk("x0",   8'(if0.cursor_x), 8'(mx[0]));
      chk("y0",   8'(if0.cursor_y), 8'(my[0]));
      chk("mov0", 8'(if0.moved),    8'(mmov[0]));
      chk("blk0", 8'(if0.blocked),  8'(mblk[0]));
      chk("x1",   8'(if1.cursor_x), 8'(mx[1]));
      chk("y1",   8'(if1.cursor_y), 8'(my[1]));
      chk("mov1", 8'(if1.moved),    8'(mmov[1]));
      chk("blk1", 8'(if1.blocked),  8'(mblk[1]));
      chk("x2",   8'(if2.cursor_x), 8'(mx[2]));
      chk("y2",   8'(if2.cursor_y), 8'(my[2]));
      chk("mov2", 8'(if2.moved),    8'(mmov[2]));
      chk("blk2", 8'(if2.blocked),  8'(mblk[2]));
   endtask

   task automatic set_keys(logic [2:0] a, logic [2:0] b, logic [2:0] c);
      kin[0] = a; kin[1] = b; kin[2] = c;
      if0.keys = a; if1.keys = b; if2.keys = c;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_reset();
      else for (int i = 0; i < 3; i++) model_edge(i);
      cyc++;
      #1;
      if (if2.moved === 1'b1) nmov2++;
      check_all();
   endtask

   // entered just after an edge; reset takes effect without waiting for a clock
   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   task automatic pulse(int i, logic [2:0] k);
      if (i == 0)      set_keys(k, K_NONE, K_NONE);
      else if (i == 1) set_keys(K_NONE, k, K_NONE);
      else             set_keys(K_NONE, K_NONE, k);
      cycle();
      set_keys(K_NONE, K_NONE, K_NONE);
      cycle();
   endtask

   initial begin
      reset = 1'b0;
      set_keys(K_NONE, K_NONE, K_NONE);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_home_x", 8'(if0.cursor_x), 8'd2);
      chk("rst_home_y", 8'(if0.cursor_y), 8'd1);
      chk("rst_moved",  8'(if0.moved),    8'd0);
      chk("rst_blocked",8'(if0.blocked),  8'd0);
      reset = 1'b1;
      cycle();

      // single one-cycle LEFT pulse
      pulse(2, K_LF);
      chk("pulse_x", 8'(if2.cursor_x), 8'd1);
      chk("pulse_mov", 8'(if2.moved), 8'd1);
      cycle();
      chk("pulse_mov_low", 8'(if2.moved), 8'd0);
      repeat (5) cycle();
      chk("pulse_no_more", 8'(if2.cursor_x), 8'd1);

      // wrap on a 5-wide grid
      pulse(0, K_LF);
      pulse(0, K_LF);
      chk("wrap_pre", 8'(if0.cursor_x), 8'd4);
      pulse(0, K_LF);
      chk("wrap_hi", 8'(if0.cursor_x), 8'd0);
      pulse(0, K_RT);
      chk("wrap_lo", 8'(if0.cursor_x), 8'd4);

      // clamp on a 3-high grid
      pulse(1, K_DN);
      pulse(1, K_DN);
      pulse(1, K_DN);
      chk("clamp_y", 8'(if1.cursor_y), 8'd2);
      chk("clamp_blk", 8'(if1.blocked), 8'd1);
      chk("clamp_mov", 8'(if1.moved), 8'd0);
      cycle();
      chk("clamp_blk_once", 8'(if1.blocked), 8'd0);
      pulse(1, K_UP);
      pulse(1, K_UP);
      pulse(1, K_UP);
      chk("clamp_y0", 8'(if1.cursor_y), 8'd0);
      chk("clamp_blk0", 8'(if1.blocked), 8'd1);

      // auto-repeat: 20 cycles of LEFT from home gives moves at 1,9,12,15,18
      do_reset();
      nmov2 = 0;
      set_keys(K_NONE, K_NONE, K_LF);
      repeat (20) cycle();
      set_keys(K_NONE, K_NONE, K_NONE);
      repeat (10) cycle();
      chk("rpt_x", 8'(if2.cursor_x), 8'd5);
      chk("rpt_nmoves", 8'(nmov2), 8'd5);

      // direction change mid-delay, then reset while held
      do_reset();
      set_keys(K_NONE, K_NONE, K_DN);
      repeat (4) cycle();
      set_keys(K_NONE, K_NONE, K_UP);
      repeat (2) cycle();
      chk("chg_y", 8'(if2.cursor_y), 8'd0);
      chk("chg_mov", 8'(if2.moved), 8'd1);
      repeat (10) cycle();
      chk("chg_rpt_y", 8'(if2.cursor_y), 8'd7);
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_rst_y", 8'(if2.cursor_y), 8'd0);
      check_all();
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      chk("post_rst_still", 8'(if2.cursor_y), 8'd0);
      cycle();
      chk("post_rst_y", 8'(if2.cursor_y), 8'd7);
      chk("post_rst_mov", 8'(if2.moved), 8'd1);

      // random holds and glitches on all three configurations
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] nk[3];
         for (int i = 0; i < 3; i++) begin
            nk[i] = kin[i];
            if ($urandom_range(3) == 0) nk[i] = 3'($urandom_range(7));
         end
         set_keys(nk[0], nk[1], nk[2]);
         if (n == 1500) do_reset();
         else cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // guard against a stalled run
   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
